// File: rtl/mc_main_ctrl_pkg.sv
// mc_pkg: shared state encodings, opcodes and select codes for the multi-cycle MIPS main control.
//   No ports. State, opcode, ALU_OP, ALUSrcB and PCSource codes, plus opcode/state classification helpers.
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction
  // The three states that wait on mem_ready and therefore own the wait timer.
  function automatic logic is_wait_state(input state_t s);
    return s == S_FETCH || s == S_MEMRD || s == S_MEMWR;
  endfunction
endpackage

// File: rtl/mc_main_ctrl_if.sv
// mc_main_ctrl_if: controller <-> datapath/memory bundle.
//   master (controller): in opcode, mem_ready; out all datapath controls, state, illegal_op, bus_err.
//   slave (datapath/bench): the mirror image.
interface mc_main_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALU_OP, PCSource;
  logic [3:0] state;
  logic       illegal_op, bus_err;
  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALU_OP, PCSource, state, illegal_op, bus_err
  );
  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALU_OP, PCSource, state, illegal_op, bus_err
  );
endinterface

// File: rtl/mc_main_ctrl_mem_wait.sv
// mc_mem_wait: memory wait counter with timeout compare.
//   clk, rst_n (sync active-low); clear restarts the count; ready holds it; timeout flags MEM_TIMEOUT-1 waited cycles.
module mc_mem_wait #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic ready,
  output logic timeout
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || clear) cnt <= '0;
    else if (!ready) cnt <= cnt + 1'b1;
  assign timeout = cnt == CNT_W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multi-cycle MIPS main control FSM.
//   clk, rst_n (sync active-low); m (master modport): opcode/mem_ready in, datapath controls,
//   state, illegal_op and bus_err out.
module mc_main_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input logic          clk,
  input logic          rst_n,
  mc_main_ctrl_if.master m
);
  state_t state_q;
  logic   timeout, abort;
  // The timer only keeps counting while a wait state is stalling; any exit, completion or abort restarts it.
  mc_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!is_wait_state(state_q) || m.mem_ready || timeout),
    .ready  (m.mem_ready),
    .timeout(timeout)
  );
  // mem_ready on the timeout cycle completes normally, so only a missing ready aborts.
  assign abort   = timeout && !m.mem_ready;
  assign m.state = state_q;
  always_ff @(posedge clk)
    if (!rst_n) state_q <= S_FETCH;
    else
      case (state_q)
        S_FETCH:  state_q <= m.mem_ready ? S_DECODE : S_FETCH;
        S_DECODE:
          case (m.opcode)
            OP_RTYPE:     state_q <= S_EXEC;
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_IEXEC;
            default:      state_q <= S_FETCH;
          endcase
        S_MEMADR: state_q <= m.opcode == OP_SW ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_q <= m.mem_ready ? S_MEMWB : timeout ? S_FETCH : S_MEMRD;
        S_MEMWR:  state_q <= m.mem_ready || timeout ? S_FETCH : S_MEMWR;
        S_EXEC:   state_q <= S_RWB;
        S_IEXEC:  state_q <= S_IWB;
        default:  state_q <= S_FETCH;
      endcase
  always_comb begin
    {m.PCWrite, m.PCWriteCond, m.IorD, m.MemRead, m.MemWrite, m.IRWrite, m.MemtoReg, m.RegDst, m.RegWrite, m.ALUSrcA} = '0;
    m.ALUSrcB    = SRCB_B;
    m.ALU_OP     = ALUOP_ADD;
    m.PCSource   = PCSRC_ALU;
    m.illegal_op = 1'b0;
    m.bus_err    = 1'b0;
    if (rst_n)
      case (state_q)
        S_FETCH: begin
          m.MemRead = 1'b1;
          m.ALUSrcB = SRCB_FOUR;
          m.IRWrite = m.mem_ready;
          m.PCWrite = m.mem_ready;
          m.bus_err = abort;
        end
        S_DECODE: begin
          m.ALUSrcB    = SRCB_IMM_SL2;
          m.illegal_op = !is_legal(m.opcode);
        end
        S_MEMADR: begin
          m.ALUSrcA = 1'b1;
          m.ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          m.MemRead = 1'b1;
          m.IorD    = 1'b1;
          m.bus_err = abort;
        end
        S_MEMWB: begin
          m.RegWrite = 1'b1;
          m.MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          m.MemWrite = 1'b1;
          m.IorD     = 1'b1;
          m.bus_err  = abort;
        end
        S_EXEC: begin
          m.ALUSrcA = 1'b1;
          m.ALU_OP  = ALUOP_FUNCT;
        end
        S_RWB: begin
          m.RegWrite = 1'b1;
          m.RegDst   = 1'b1;
        end
        S_BRANCH: begin
          m.ALUSrcA     = 1'b1;
          m.ALU_OP      = ALUOP_SUB;
          m.PCWriteCond = 1'b1;
          m.PCSource    = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          m.PCWrite  = 1'b1;
          m.PCSource = PCSRC_JUMP;
        end
        S_IEXEC: begin
          m.ALUSrcA = 1'b1;
          m.ALUSrcB = SRCB_IMM;
        end
        S_IWB:   m.RegWrite = 1'b1;
        default: ;
      endcase
  end
endmodule
